// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, oversampled majority-vote bit recovery,
// LSB-first deserialisation, optional parity check and one/two stop-bit check.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STP2,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w, input logic odd);
        return (^w) ^ odd;
    endfunction

    state_t                state_r;
    logic [PW-1:0]         edge_cnt_r;
    logic [PW-1:0]         p_r;
    logic [BW-1:0]         bit_cnt_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  stp2_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [2:0]            smp_r;
    logic                  par_bad_r;
    logic                  stp_bad_r;

    logic [PW-1:0]         last_edge_s;
    logic [PW-1:0]         pre_edge_s;
    logic [PW-1:0]         mid_edge_s;
    logic [PW-1:0]         mid_lo_s;
    logic [PW-1:0]         mid_hi_s;
    logic [BW-1:0]         last_bit_s;
    logic                  edge_last_s;
    logic                  edge_pre_s;
    logic                  samp_bit_s;
    logic                  in_frame_s;
    logic                  par_fail_s;
    logic                  stp_fail_s;

    // Bit-timing decode from the configuration latched at the start edge
    always_comb begin
        last_edge_s = p_r - PW'(1);
        pre_edge_s  = p_r - PW'(2);
        mid_edge_s  = {1'b0, p_r[PW-1:1]};
        mid_lo_s    = mid_edge_s - PW'(1);
        mid_hi_s    = mid_edge_s + PW'(1);
        last_bit_s  = BW'(DATA_WIDTH) + {3'b000, par_en_r} + BW'(1) + {3'b000, stp2_r};
        edge_last_s = (edge_cnt_r == last_edge_s);
        edge_pre_s  = (edge_cnt_r == pre_edge_s);
        samp_bit_s  = majority3(smp_r[0], smp_r[1], smp_r[2]);
        in_frame_s  = (state_r == START) || (state_r == DATA) ||
                      (state_r == PARITY) || (state_r == STOP);
        par_fail_s  = par_en_r & par_bad_r;
        stp_fail_s  = stp_bad_r | ~samp_bit_s;
    end

    assign busy = (state_r != IDLE);

    // Capture the three samples around mid-bit for the majority vote
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp_r <= 3'b000;
        end else if (in_frame_s) begin
            if (edge_cnt_r == mid_lo_s) smp_r[0] <= RX_IN;
            if (edge_cnt_r == mid_edge_s) smp_r[1] <= RX_IN;
            if (edge_cnt_r == mid_hi_s) smp_r[2] <= RX_IN;
        end
    end

    // Frame FSM with edge/bit counters, deserialiser and registered result flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= IDLE;
            edge_cnt_r <= {PW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            p_r        <= {PW{1'b0}};
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            stp2_r     <= 1'b0;
            shift_r    <= {DATA_WIDTH{1'b0}};
            par_bad_r  <= 1'b0;
            stp_bad_r  <= 1'b0;
            P_DATA     <= {DATA_WIDTH{1'b0}};
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (edge_last_s) begin
                edge_cnt_r <= {PW{1'b0}};
                bit_cnt_r  <= bit_cnt_r + BW'(1);
            end else begin
                edge_cnt_r <= edge_cnt_r + PW'(1);
            end
            case (state_r)
                IDLE: begin
                    edge_cnt_r <= {PW{1'b0}};
                    bit_cnt_r  <= {BW{1'b0}};
                    if (!RX_IN) begin
                        // The detection cycle is edge 0 of the start bit
                        state_r    <= START;
                        edge_cnt_r <= PW'(1);
                        p_r        <= prescale;
                        par_en_r   <= PAR_EN;
                        par_typ_r  <= PAR_TYP;
                        stp2_r     <= STP2;
                        par_bad_r  <= 1'b0;
                        stp_bad_r  <= 1'b0;
                    end
                end
                START: begin
                    if (edge_last_s) begin
                        if (samp_bit_s) begin
                            state_r    <= IDLE;
                            edge_cnt_r <= {PW{1'b0}};
                            bit_cnt_r  <= {BW{1'b0}};
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (edge_last_s) begin
                        shift_r <= {samp_bit_s, shift_r[DATA_WIDTH-1:1]};
                        if (bit_cnt_r == BW'(DATA_WIDTH)) begin
                            state_r <= par_en_r ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (edge_last_s) begin
                        par_bad_r <= samp_bit_s ^ word_parity(shift_r, par_typ_r);
                        state_r   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_cnt_r == last_bit_s) begin
                        // Decide one cycle early so the flags are registered for OUTPUT
                        if (edge_pre_s) begin
                            state_r <= OUTPUT;
                            par_err <= par_fail_s;
                            stp_err <= stp_fail_s;
                            if (!par_fail_s && !stp_fail_s) begin
                                data_valid <= 1'b1;
                                P_DATA     <= shift_r;
                            end
                        end
                    end else if (edge_last_s) begin
                        stp_bad_r <= stp_bad_r | ~samp_bit_s;
                    end
                end
                OUTPUT: begin
                    state_r    <= IDLE;
                    edge_cnt_r <= {PW{1'b0}};
                    bit_cnt_r  <= {BW{1'b0}};
                end
                default: begin
                    state_r    <= IDLE;
                    edge_cnt_r <= {PW{1'b0}};
                    bit_cnt_r  <= {BW{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a frame table plus hand-written glitch, break,
// back-to-back, 7-bit/mid-frame-config and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic       sel;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       stp2;
    logic       rx8;
    logic       rx7;
    logic [7:0] pdata8;
    logic [6:0] pdata7;
    logic       dv8, pe8, se8, busy8;
    logic       dv7, pe7, se7, busy7;
    logic [8:0] obs_pdata;
    logic       obs_dv, obs_pe, obs_se, obs_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int dv_cyc, pe_cyc, se_cyc, pulses, nb;
    bit busy_ok;
    logic [15:0] bits;

    typedef struct {
        int         p;
        logic       pe;
        logic       pt;
        logic       s2;
        logic       flip;
        logic [1:0] stops;
        logic [8:0] word;
        logic       exp_dv;
        logic       exp_pe;
        logic       exp_se;
        logic [8:0] exp_pdata;
    } vec_t;
    vec_t vecs [8];
    vec_t v;

    always #5 clk = ~clk;

    assign rx8 = sel ? 1'b1 : line;
    assign rx7 = sel ? line : 1'b1;
    assign obs_pdata = sel ? {2'b00, pdata7} : {1'b0, pdata8};
    assign obs_dv    = sel ? dv7 : dv8;
    assign obs_pe    = sel ? pe7 : pe8;
    assign obs_se    = sel ? se7 : se8;
    assign obs_busy  = sel ? busy7 : busy8;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx8), .prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STP2(stp2), .P_DATA(pdata8), .data_valid(dv8),
        .par_err(pe8), .stp_err(se8), .busy(busy8));

    uart_rx_ctrl #(.DATA_WIDTH(7), .PRESCALE_WIDTH(6)) dut7 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx7), .prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STP2(stp2), .P_DATA(pdata7), .data_valid(dv7),
        .par_err(pe7), .stp_err(se7), .busy(busy7));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Line values of one frame, bit 0 first; unused upper bits idle high
    function automatic logic [15:0] build_bits(input int dw, input logic [8:0] word,
                                               input logic pe, input logic pt, input logic s2,
                                               input logic flip, input logic [1:0] stops,
                                               output int n);
        logic [15:0] b;
        logic        pbit;
        int          idx;
        b    = 16'hFFFF;
        b[0] = 1'b0;
        idx  = 1;
        pbit = pt ^ flip;
        for (int i = 0; i < dw; i++) begin
            b[idx] = word[i];
            pbit   = pbit ^ word[i];
            idx++;
        end
        if (pe) begin
            b[idx] = pbit;
            idx++;
        end
        b[idx] = stops[0];
        idx++;
        if (s2) begin
            b[idx] = stops[1];
            idx++;
        end
        n = idx;
        return b;
    endfunction

    task automatic note_pulses(input int c);
        if (obs_dv) dv_cyc = (dv_cyc == -1) ? c : -2;
        if (obs_pe) pe_cyc = (pe_cyc == -1) ? c : -2;
        if (obs_se) se_cyc = (se_cyc == -1) ? c : -2;
    endtask

    // Drive cycles 0..p*n-1 of a frame; cycle c is sampled at its negedge before driving
    task automatic drive_frame(input int p, input int n, input logic [15:0] b,
                               input int chg_at, input int rst_at);
        dv_cyc  = -1;
        pe_cyc  = -1;
        se_cyc  = -1;
        busy_ok = 1'b1;
        for (int c = 0; c < p * n; c++) begin
            @(negedge clk);
            note_pulses(c);
            if (obs_busy !== (c != 0)) busy_ok = 1'b0;
            if (c == chg_at) begin
                prescale = 6'd8;
                stp2     = ~stp2;
                par_en   = ~par_en;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                line  = 1'b1;
                #1;
                chk("rst_pdata", obs_pdata, 0);
                chk("rst_dv", obs_dv, 0);
                chk("rst_pe", obs_pe, 0);
                chk("rst_se", obs_se, 0);
                chk("rst_busy", obs_busy, 0);
                break;
            end
            line = b[c / p];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        if (obs_dv) dv_cyc = -2;
        if (obs_pe) pe_cyc = -2;
        if (obs_se) se_cyc = -2;
        if (obs_busy) busy_ok = 1'b0;
        line = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int pn, input logic edv,
                               input logic epe, input logic ese, input int epdata);
        chk({tag, "_dv_cycle"}, dv_cyc, edv ? pn - 1 : -1);
        chk({tag, "_pe_cycle"}, pe_cyc, epe ? pn - 1 : -1);
        chk({tag, "_se_cycle"}, se_cyc, ese ? pn - 1 : -1);
        chk({tag, "_pdata"}, obs_pdata, epdata);
        chk({tag, "_busy"}, busy_ok, 1);
    endtask

    initial begin
        //           p  pe    pt    s2    flip  stops  word     dv    pe    se    pdata
        vecs[0] = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'h0A5, 1'b1, 1'b0, 1'b0, 9'h0A5};
        vecs[1] = '{16, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 9'h03C, 1'b0, 1'b1, 1'b0, 9'h0A5};
        vecs[2] = '{8,  1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 9'h081, 1'b0, 1'b0, 1'b1, 9'h0A5};
        vecs[3] = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0, 1'b0, 9'h007};
        vecs[4] = '{62, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 9'h0C3, 1'b1, 1'b0, 1'b0, 9'h0C3};
        vecs[5] = '{8,  1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 9'h000, 1'b0, 1'b0, 1'b1, 9'h0C3};
        vecs[6] = '{12, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 9'h0E1, 1'b0, 1'b1, 1'b1, 9'h0C3};
        vecs[7] = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'h0FF, 1'b1, 1'b0, 1'b0, 9'h0FF};

        rst_n = 1'b0; line = 1'b1; sel = 1'b0;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stp2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pdata8", obs_pdata, 0);
        chk("reset_dv8", obs_dv, 0);
        chk("reset_flags8", {obs_pe, obs_se}, 0);
        chk("reset_busy8", obs_busy, 0);
        sel = 1'b1;
        #1;
        chk("reset_pdata7", obs_pdata, 0);
        chk("reset_busy7", obs_busy, 0);
        sel = 1'b0;

        for (int i = 0; i < 8; i++) begin
            v        = vecs[i];
            prescale = 6'(v.p);
            par_en   = v.pe;
            par_typ  = v.pt;
            stp2     = v.s2;
            bits = build_bits(8, v.word, v.pe, v.pt, v.s2, v.flip, v.stops, nb);
            drive_frame(v.p, nb, bits, -1, -1);
            end_frame();
            check_frame($sformatf("vec%0d", i), v.p * nb, v.exp_dv, v.exp_pe, v.exp_se,
                        int'(v.exp_pdata));
        end

        // Start glitch: two low cycles, then high; must abort at cycle 16
        prescale = 6'd16; par_en = 1'b0; stp2 = 1'b0;
        pulses = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (obs_dv | obs_pe | obs_se) pulses++;
            if (c == 15) chk("glitch_busy15", obs_busy, 1);
            if (c == 16) chk("glitch_idle16", obs_busy, 0);
            line = (c < 2) ? 1'b0 : 1'b1;
        end
        chk("glitch_flags", pulses, 0);
        chk("glitch_pdata", obs_pdata, 32'h0FF);
        bits = build_bits(8, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, nb);
        drive_frame(16, nb, bits, -1, -1);
        end_frame();
        check_frame("after_glitch", 16 * nb, 1'b1, 1'b0, 1'b0, 32'h05A);

        // Break (line low throughout) followed immediately by a new frame
        prescale = 6'd8;
        drive_frame(8, 10, 16'h0000, -1, -1);
        check_frame("break", 80, 1'b0, 1'b0, 1'b1, 32'h05A);
        bits = build_bits(8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, nb);
        drive_frame(8, nb, bits, -1, -1);
        end_frame();
        check_frame("b2b", 8 * nb, 1'b1, 1'b0, 1'b0, 32'h0A5);

        // 7-bit instance, p=32 even parity, configuration disturbed mid-frame
        sel = 1'b1; prescale = 6'd32; par_en = 1'b1; par_typ = 1'b0; stp2 = 1'b0;
        bits = build_bits(7, 9'h055, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, nb);
        drive_frame(32, nb, bits, 100, -1);
        end_frame();
        check_frame("dw7", 32 * nb, 1'b1, 1'b0, 1'b0, 32'h055);
        chk("dw7_frame_len", 32 * nb, 320);
        sel = 1'b0; prescale = 6'd8; par_en = 1'b0; stp2 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset at cycle 40 of a frame, then a clean 0xFF frame
        bits = build_bits(8, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, nb);
        drive_frame(8, nb, bits, -1, 40);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bits = build_bits(8, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, nb);
        drive_frame(8, nb, bits, -1, -1);
        end_frame();
        check_frame("post_reset", 8 * nb, 1'b1, 1'b0, 1'b0, 32'h0FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
